ar_pack_writer: RTL

Controller that packs rounded coefficient beats (4 × 10-bit = 40 bits) into the 320-bit low region of the shared buffer and writes the packed result to memory as 64-bit words. It sits upstream of the shared buffer on the add-and-round path:
- feeds the buffer through the 40-bit push port;
- drains it through the 64-bit shift port.

Each group is 8 beats = 320 bits = 5 memory words, little-endian: the first beat lands in the lowest bits of the first word.

---
 rtl/ar_pack_writer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ar_pack_writer.sv
// Packs 40-bit rounded coefficient beats into the shared 320-bit buffer and drains it as 64-bit words.
// Optional macro AR_PACK_PARTIAL_FLUSH_EN: zero-pad and flush a trailing partial group of 1..7 beats.
module ar_pack_writer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  len_beats,
    input  logic [7:0]  base_addr,
    input  logic [39:0] rnd_data,
    input  logic        rnd_valid,
    output logic        rnd_ready,
    output logic        buf_req,
    input  logic        buf_gnt,
    output logic        AR_buffer40_en,
    output logic [39:0] AR_buffer40_data,
    output logic        AR_buffer64_en,
    input  logic [63:0] buf_lo,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [63:0] mem_wdata,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] { S_IDLE, S_FILL, S_DRAIN, S_FIN } state_t;

    state_t     r_state, w_state_nx;
    logic [3:0] r_cnt,   w_cnt_nx;
    logic [7:0] r_rem,   w_rem_nx;
    logic [7:0] r_addr,  w_addr_nx;
    logic [2:0] r_words, w_words_nx;
    logic [7:0] w_len_eff;
    logic       w_flush;

`ifdef AR_PACK_PARTIAL_FLUSH_EN
    assign w_len_eff = len_beats;
    assign w_flush   = 1'b1;
`else
    assign w_len_eff = len_beats & 8'hF8;
    assign w_flush   = 1'b0;
`endif

    // Memory words needed to hold n real beats: ceil(40*n/64).
    function automatic logic [2:0] words_for(input logic [3:0] n);
        case (n)
            4'd1:       return 3'd1;
            4'd2, 4'd3: return 3'd2;
            4'd4:       return 3'd3;
            4'd5, 4'd6: return 3'd4;
            default:    return 3'd5;
        endcase
    endfunction

    always_comb begin
        // NOTE: every next-state value and output gets a default first, so no path can infer a latch.
        w_state_nx       = r_state;
        w_cnt_nx         = r_cnt;
        w_rem_nx         = r_rem;
        w_addr_nx        = r_addr;
        w_words_nx       = r_words;
        rnd_ready        = 1'b0;
        buf_req          = 1'b0;
        AR_buffer40_en   = 1'b0;
        AR_buffer40_data = '0;
        AR_buffer64_en   = 1'b0;
        mem_we           = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        busy             = (r_state != S_IDLE);
        done             = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_rem_nx   = w_len_eff;
                    w_addr_nx  = base_addr;
                    w_cnt_nx   = '0;
                    // An empty job passes through one FILL cycle, which places done two cycles after start.
                    w_state_nx = S_FILL;
                end
            end
            S_FILL: begin
                buf_req = 1'b1;
                if (r_rem != '0) begin
                    rnd_ready        = buf_gnt && (r_cnt < 4'd8);
                    AR_buffer40_data = rnd_data;
                    if (rnd_valid && rnd_ready) begin
                        AR_buffer40_en = 1'b1;
                        w_cnt_nx       = r_cnt + 4'd1;
                        w_rem_nx       = r_rem - 8'd1;
                        w_words_nx     = words_for(r_cnt + 4'd1);
                        if (r_cnt == 4'd7)
                            w_state_nx = S_DRAIN;
                    end
                end else if (r_cnt == '0) begin
                    w_state_nx = S_FIN;
                end else if (w_flush && buf_gnt) begin
                    // Zero beats pad the trailing group so its first beat reaches buffer[39:0].
                    AR_buffer40_en = 1'b1;
                    w_cnt_nx       = r_cnt + 4'd1;
                    if (r_cnt == 4'd7)
                        w_state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                buf_req = 1'b1;
                if (buf_gnt) begin
                    AR_buffer64_en = 1'b1;
                    mem_we         = 1'b1;
                    mem_addr       = r_addr;
                    mem_wdata      = buf_lo;
                    w_addr_nx      = r_addr + 8'd1;
                    w_words_nx     = r_words - 3'd1;
                    if (r_words <= 3'd1) begin
                        w_cnt_nx   = '0;
                        w_state_nx = (r_rem == '0) ? S_FIN : S_FILL;
                    end
                end
            end
            S_FIN: begin
                done       = 1'b1;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments; reset is asynchronous so outputs clear immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_addr  <= '0;
            r_words <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_rem   <= w_rem_nx;
            r_addr  <= w_addr_nx;
            r_words <= w_words_nx;
        end
    end

endmodule
